// File: rtl/usb4_enc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb4_enc_pkg : shared constants for the USB4 transmit lane encoder
// Rev 1.0
// ----------------------------------------------------------------------------
package usb4_enc_pkg;

  localparam logic [1:0] GEN4 = 2'd0;
  localparam logic [1:0] GEN3 = 2'd1;
  localparam logic [1:0] GEN2 = 2'd2;

  localparam logic [3:0] HDR128_DATA = 4'b0101;
  localparam logic [3:0] HDR128_OS   = 4'b1010;
  localparam logic [1:0] HDR66_DATA  = 2'b01;
  localparam logic [1:0] HDR66_OS    = 2'b10;

  localparam int BYTES_GEN3 = 16;
  localparam int BYTES_GEN2 = 8;
  localparam int BYTES_GEN4 = 1;

  localparam int ENC_W = 132;

endpackage
`default_nettype wire

// File: rtl/enc_lane_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// enc_lane_packer : per-lane byte store and 128b/132b, 64b/66b, pass-through mux
// Rev 1.0
// ----------------------------------------------------------------------------
module enc_lane_packer #(
  parameter logic [1:0] GEN3 = 2'd1,
  parameter logic [1:0] GEN2 = 2'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic         i_complete,
  input  logic [3:0]   i_byte_cnt,
  input  logic [1:0]   i_gen_l,
  input  logic         i_dos_l,
  input  logic [7:0]   i_byte,
  output logic [131:0] o_enc
);
  import usb4_enc_pkg::*;

  logic [7:0]   r_store [16];
  logic [7:0]   w_bytes [16];
  logic [131:0] w_block;
  logic [131:0] r_enc;

  // The completing byte is merged combinationally so the block registers on the same edge.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_bytes[i] = r_store[i];
    end
    w_bytes[i_byte_cnt] = i_byte;

    w_block = '0;
    if (i_gen_l == GEN3) begin
      w_block[3:0] = i_dos_l ? HDR128_DATA : HDR128_OS;
      for (int i = 0; i < BYTES_GEN3; i++) begin
        w_block[4 + 8*i +: 8] = w_bytes[i];
      end
    end else if (i_gen_l == GEN2) begin
      w_block[1:0] = i_dos_l ? HDR66_DATA : HDR66_OS;
      for (int i = 0; i < BYTES_GEN2; i++) begin
        w_block[2 + 8*i +: 8] = w_bytes[i];
      end
    end else begin
      w_block[7:0] = i_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_store[i] <= '0;
      end
      r_enc <= '0;
    end else begin
      if (i_wr_en) begin
        r_store[i_byte_cnt] <= i_byte;
      end
      if (i_complete) begin
        r_enc <= w_block;
      end
    end
  end

  assign o_enc = r_enc;

endmodule
`default_nettype wire

// File: rtl/encoding_block.sv
`default_nettype none
// ----------------------------------------------------------------------------
// encoding_block : USB4 transmit lane encoder, two lanes, Gen2/Gen3/Gen4
// Rev 1.0
// ----------------------------------------------------------------------------
module encoding_block #(
  parameter logic [1:0] GEN4 = 2'd0,
  parameter logic [1:0] GEN3 = 2'd1,
  parameter logic [1:0] GEN2 = 2'd2
) (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         enable_enc,
  input  logic [1:0]   gen_speed,
  input  logic         data_os,
  input  logic [7:0]   lane_0_tx,
  input  logic [7:0]   lane_1_tx,
  output logic [131:0] lane_0_tx_enc,
  output logic [131:0] lane_1_tx_enc,
  output logic         enc_valid
);
  import usb4_enc_pkg::*;

  logic [3:0] r_byte_cnt;
  logic [1:0] r_gen_l;
  logic       r_dos_l;
  logic       r_valid;

  logic [1:0] w_gen_eff;
  logic       w_dos_eff;
  logic [3:0] w_max;
  logic       w_reserved;
  logic       w_wr;
  logic       w_complete;

  // At byte 0 the live inputs define the block; afterwards the latched copies do.
  always_comb begin
    w_gen_eff  = (r_byte_cnt == 4'd0) ? gen_speed : r_gen_l;
    w_dos_eff  = (r_byte_cnt == 4'd0) ? data_os   : r_dos_l;
    w_max      = 4'd0;
    w_reserved = 1'b1;
    if (w_gen_eff == GEN3) begin
      w_max      = 4'(BYTES_GEN3 - 1);
      w_reserved = 1'b0;
    end else if (w_gen_eff == GEN2) begin
      w_max      = 4'(BYTES_GEN2 - 1);
      w_reserved = 1'b0;
    end else if (w_gen_eff == GEN4) begin
      w_max      = 4'(BYTES_GEN4 - 1);
      w_reserved = 1'b0;
    end
    w_wr       = enable_enc && !w_reserved;
    w_complete = w_wr && (r_byte_cnt == w_max);
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
      r_gen_l    <= '0;
      r_dos_l    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_complete;
      if (w_wr && !w_complete) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end else begin
        r_byte_cnt <= '0;
      end
      if (enable_enc && (r_byte_cnt == 4'd0)) begin
        r_gen_l <= gen_speed;
        r_dos_l <= data_os;
      end
    end
  end

  assign enc_valid = r_valid;

  enc_lane_packer #(
    .GEN3 (GEN3),
    .GEN2 (GEN2)
  ) u_lane0 (
    .clk        (enc_clk),
    .rst_n      (rst),
    .i_wr_en    (w_wr),
    .i_complete (w_complete),
    .i_byte_cnt (r_byte_cnt),
    .i_gen_l    (w_gen_eff),
    .i_dos_l    (w_dos_eff),
    .i_byte     (lane_0_tx),
    .o_enc      (lane_0_tx_enc)
  );

  enc_lane_packer #(
    .GEN3 (GEN3),
    .GEN2 (GEN2)
  ) u_lane1 (
    .clk        (enc_clk),
    .rst_n      (rst),
    .i_wr_en    (w_wr),
    .i_complete (w_complete),
    .i_byte_cnt (r_byte_cnt),
    .i_gen_l    (w_gen_eff),
    .i_dos_l    (w_dos_eff),
    .i_byte     (lane_1_tx),
    .o_enc      (lane_1_tx_enc)
  );

endmodule
`default_nettype wire
